ifid_hazard_ctrl: RTL and testbench

- Hazard/stall sequencer for the front of the 5-stage MIPS pipeline.
- Detects load-use hazards, taken-branch redirects and instruction-memory wait.
- Drives the IF/ID register's {dataStall, controlStall} pair, PC write-enable and an ID/EX bubble request.
- Keeps a saturating stall-cycle counter for debug.

---
 rtl/ifid_hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ifid_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifid_hazard_ctrl.sv
// ifid_hazard_ctrl
//   Front-end hazard/stall sequencer for the 5-stage MIPS pipeline. It detects
//   load-use hazards, taken-branch redirects and instruction-memory wait. From
//   these it drives the IF/ID {dataStall, controlStall} pair, the PC
//   write-enable and an ID/EX bubble request. It also keeps a saturating count
//   of cycles in which the front end did not advance.
//
//   IF/ID encoding {oDataStall, oControlStall}:
//     11 = ADVANCE, 10 = FLUSH, 01 = HOLD
//
// Ports
//   clk            clock, all state updates on posedge
//   reset          synchronous, active-high
//   iIdRs/iIdRt    source register fields of the instruction in ID
//   iIdUsesRs/Rt   ID instruction reads rs / rt
//   iExMemRead     instruction in EX is a load
//   iExRd          destination register of the instruction in EX
//   iBranchTaken   branch in EX resolved taken this cycle
//   iImemReady     instruction memory returns valid data this cycle
//   oDataStall     IF/ID dataStall
//   oControlStall  IF/ID controlStall
//   oPCWrite       PC load enable
//   oIdExBubble    ID/EX register loads a NOP
//   oStallCycles   saturating count of non-advancing front-end cycles
module ifid_hazard_ctrl #(
    parameter int unsigned LOAD_USE_STALL = 1,
    parameter int unsigned BRANCH_FLUSH   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  iIdRs,
    input  logic [4:0]  iIdRt,
    input  logic        iIdUsesRs,
    input  logic        iIdUsesRt,
    input  logic        iExMemRead,
    input  logic [4:0]  iExRd,
    input  logic        iBranchTaken,
    input  logic        iImemReady,
    output logic        oDataStall,
    output logic        oControlStall,
    output logic        oPCWrite,
    output logic        oIdExBubble,
    output logic [15:0] oStallCycles
);

    typedef enum logic [1:0] {
        RUN,
        LU_STALL,
        BR_FLUSH
    } state_e;

    localparam logic [1:0] ENC_ADVANCE = 2'b11;
    localparam logic [1:0] ENC_FLUSH   = 2'b10;
    localparam logic [1:0] ENC_HOLD    = 2'b01;

    // Remaining cycles after the one in which the event is detected.
    localparam logic [2:0] LU_RELOAD = 3'(LOAD_USE_STALL - 1);
    localparam logic [2:0] BR_RELOAD = 3'(BRANCH_FLUSH - 1);
    localparam bit         LU_MULTI  = (LOAD_USE_STALL > 1);
    localparam bit         BR_MULTI  = (BRANCH_FLUSH > 1);

    state_e      state;
    state_e      stateNext;
    logic [2:0]  cnt;
    logic [2:0]  cntNext;
    logic [15:0] stallCount;
    logic [1:0]  ifidCtrl;
    logic        hazard;

    // $0 is hardwired, so a load targeting it never creates a dependency.
    assign hazard = iExMemRead && (iExRd != 5'd0) &&
                    ((iIdUsesRs && (iIdRs == iExRd)) ||
                     (iIdUsesRt && (iIdRt == iExRd)));

    // State register and debug counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            cnt        <= '0;
            stallCount <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if ((ifidCtrl != ENC_ADVANCE) && (stallCount != '1)) begin
                stallCount <= stallCount + 16'd1;
            end
        end
    end

    // Next-state logic. A taken branch takes priority in every state and
    // (re)starts the flush window.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        if (iBranchTaken) begin
            stateNext = BR_MULTI ? BR_FLUSH : RUN;
            cntNext   = BR_MULTI ? BR_RELOAD : 3'd0;
        end else begin
            unique case (state)
                RUN: begin
                    if (hazard && LU_MULTI) begin
                        stateNext = LU_STALL;
                        cntNext   = LU_RELOAD;
                    end
                end
                LU_STALL, BR_FLUSH: begin
                    if (cnt == 3'd1) begin
                        stateNext = RUN;
                        cntNext   = 3'd0;
                    end else begin
                        cntNext = cnt - 3'd1;
                    end
                end
                default: begin
                    stateNext = RUN;
                    cntNext   = 3'd0;
                end
            endcase
        end
    end

    // Output logic (Mealy on state and inputs).
    always_comb begin
        ifidCtrl    = ENC_ADVANCE;
        oPCWrite    = 1'b1;
        oIdExBubble = 1'b0;
        if (reset) begin
            ifidCtrl    = ENC_FLUSH;
            oPCWrite    = 1'b0;
            oIdExBubble = 1'b1;
        end else if (iBranchTaken) begin
            ifidCtrl    = ENC_FLUSH;
            oPCWrite    = 1'b1;
            oIdExBubble = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    if (hazard) begin
                        ifidCtrl    = ENC_HOLD;
                        oPCWrite    = 1'b0;
                        oIdExBubble = 1'b1;
                    end else if (!iImemReady) begin
                        ifidCtrl    = ENC_FLUSH;
                        oPCWrite    = 1'b0;
                        oIdExBubble = 1'b0;
                    end
                end
                LU_STALL: begin
                    ifidCtrl    = ENC_HOLD;
                    oPCWrite    = 1'b0;
                    oIdExBubble = 1'b1;
                end
                BR_FLUSH: begin
                    ifidCtrl    = ENC_FLUSH;
                    oPCWrite    = iImemReady;
                    oIdExBubble = 1'b1;
                end
                default: begin
                    ifidCtrl    = ENC_FLUSH;
                    oPCWrite    = 1'b0;
                    oIdExBubble = 1'b1;
                end
            endcase
        end
    end

    assign oDataStall    = ifidCtrl[1];
    assign oControlStall = ifidCtrl[0];
    assign oStallCycles  = stallCount;

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// tb_ifid_hazard_ctrl
//   Directed bench for ifid_hazard_ctrl. Two instances share the same
//   stimulus: dutD uses default parameters (1/1), dutC uses
//   LOAD_USE_STALL=3, BRANCH_FLUSH=2. Inputs change on negedge clk and
//   outputs are checked 1 time unit later, before the next posedge.
module tb_ifid_hazard_ctrl;

    localparam logic [1:0] ADV   = 2'b11;
    localparam logic [1:0] FLUSH = 2'b10;
    localparam logic [1:0] HOLD  = 2'b01;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  idRs, idRt, exRd;
    logic        idUsesRs, idUsesRt, exMemRead, branchTaken, imemReady;

    logic        dsD, csD, pcD, bubD;
    logic [15:0] scD;
    logic        dsC, csC, pcC, bubC;
    logic [15:0] scC;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    ifid_hazard_ctrl dutD (
        .clk(clk), .reset(reset),
        .iIdRs(idRs), .iIdRt(idRt), .iIdUsesRs(idUsesRs), .iIdUsesRt(idUsesRt),
        .iExMemRead(exMemRead), .iExRd(exRd),
        .iBranchTaken(branchTaken), .iImemReady(imemReady),
        .oDataStall(dsD), .oControlStall(csD), .oPCWrite(pcD),
        .oIdExBubble(bubD), .oStallCycles(scD)
    );

    ifid_hazard_ctrl #(.LOAD_USE_STALL(3), .BRANCH_FLUSH(2)) dutC (
        .clk(clk), .reset(reset),
        .iIdRs(idRs), .iIdRt(idRt), .iIdUsesRs(idUsesRs), .iIdUsesRt(idUsesRt),
        .iExMemRead(exMemRead), .iExRd(exRd),
        .iBranchTaken(branchTaken), .iImemReady(imemReady),
        .oDataStall(dsC), .oControlStall(csC), .oPCWrite(pcC),
        .oIdExBubble(bubC), .oStallCycles(scC)
    );

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expectD(input string tag, input logic [1:0] enc,
                           input logic pc, input logic bub);
        checkVal({tag, ".D.enc"}, 32'({dsD, csD}), 32'(enc));
        checkVal({tag, ".D.pc"},  32'(pcD),        32'(pc));
        checkVal({tag, ".D.bub"}, 32'(bubD),       32'(bub));
    endtask

    task automatic expectC(input string tag, input logic [1:0] enc,
                           input logic pc, input logic bub);
        checkVal({tag, ".C.enc"}, 32'({dsC, csC}), 32'(enc));
        checkVal({tag, ".C.pc"},  32'(pcC),        32'(pc));
        checkVal({tag, ".C.bub"}, 32'(bubC),       32'(bub));
    endtask

    // Idle defaults: no hazard, no branch, memory ready, reset released.
    task automatic idle();
        reset       = 1'b0;
        idRs        = 5'd0;
        idRt        = 5'd0;
        exRd        = 5'd0;
        idUsesRs    = 1'b0;
        idUsesRt    = 1'b0;
        exMemRead   = 1'b0;
        branchTaken = 1'b0;
        imemReady   = 1'b1;
    endtask

    // Advance to the next negedge and apply idle defaults.
    task automatic nextCycle();
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;

        // Reset: two cycles.
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            reset = 1'b1;
            #1;
            expectD("rst", FLUSH, 1'b0, 1'b1);
            expectC("rst", FLUSH, 1'b0, 1'b1);
        end

        // Five cycles of plain advance.
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            #1;
            expectD("run", ADV, 1'b1, 1'b0);
            expectC("run", ADV, 1'b1, 1'b0);
        end
        checkVal("run.D.sc", 32'(scD), 32'd0);

        // Load-use on rs=8 for one cycle. dutD holds once; dutC holds 3 cycles.
        nextCycle();
        exMemRead = 1'b1; exRd = 5'd8; idRs = 5'd8; idUsesRs = 1'b1;
        #1;
        expectD("luRs", HOLD, 1'b0, 1'b1);
        expectC("luRs", HOLD, 1'b0, 1'b1);
        nextCycle();
        #1;
        expectD("luRs+1", ADV, 1'b1, 1'b0);
        expectC("luRs+1", HOLD, 1'b0, 1'b1);
        checkVal("luRs.D.sc", 32'(scD), 32'd1);
        nextCycle();
        #1;
        expectC("luRs+2", HOLD, 1'b0, 1'b1);
        nextCycle();
        #1;
        expectC("luRs+3", ADV, 1'b1, 1'b0);
        checkVal("luRs.C.sc", 32'(scC), 32'd3);

        // Load to $0 followed by a use of $0 advances.
        nextCycle();
        exMemRead = 1'b1; exRd = 5'd0; idRs = 5'd0; idUsesRs = 1'b1;
        #1;
        expectD("zero", ADV, 1'b1, 1'b0);
        expectC("zero", ADV, 1'b1, 1'b0);

        // Unused source field matches: no hazard.
        nextCycle();
        exMemRead = 1'b1; exRd = 5'd9; idRt = 5'd9; idUsesRt = 1'b0;
        #1;
        expectD("noUse", ADV, 1'b1, 1'b0);

        // Load-use on rt=5; branch in dutC's 2nd stall cycle ends the stall.
        nextCycle();
        exMemRead = 1'b1; exRd = 5'd5; idRt = 5'd5; idUsesRt = 1'b1;
        #1;
        expectC("luRt", HOLD, 1'b0, 1'b1);
        expectD("luRt", HOLD, 1'b0, 1'b1);
        nextCycle();
        branchTaken = 1'b1;
        #1;
        expectC("luBr", FLUSH, 1'b1, 1'b1);
        expectD("luBr", FLUSH, 1'b1, 1'b1);
        nextCycle();
        #1;
        expectC("luBr+1", FLUSH, 1'b1, 1'b1);
        expectD("luBr+1", ADV, 1'b1, 1'b0);
        nextCycle();
        #1;
        expectC("luBr+2", ADV, 1'b1, 1'b0);

        // Branch flush window of 2 with memory not ready in the 2nd cycle.
        nextCycle();
        branchTaken = 1'b1;
        #1;
        expectC("br", FLUSH, 1'b1, 1'b1);
        nextCycle();
        imemReady = 1'b0;
        #1;
        expectC("br+1", FLUSH, 1'b0, 1'b1);
        expectD("br+1", FLUSH, 1'b0, 1'b0);
        nextCycle();
        #1;
        expectC("br+2", ADV, 1'b1, 1'b0);

        // Second branch inside the window restarts it; hazard ignored there.
        nextCycle();
        branchTaken = 1'b1;
        #1;
        expectC("br2", FLUSH, 1'b1, 1'b1);
        nextCycle();
        branchTaken = 1'b1;
        #1;
        expectC("br2+1", FLUSH, 1'b1, 1'b1);
        nextCycle();
        exMemRead = 1'b1; exRd = 5'd3; idRs = 5'd3; idUsesRs = 1'b1;
        #1;
        expectC("br2+2", FLUSH, 1'b1, 1'b1);
        nextCycle();
        #1;
        expectC("br2+3", ADV, 1'b1, 1'b0);

        // Memory wait for 4 cycles from a freshly cleared counter.
        nextCycle();
        reset = 1'b1;
        #1;
        expectD("rst2", FLUSH, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            imemReady = 1'b0;
            #1;
            expectD("wait", FLUSH, 1'b0, 1'b0);
            expectC("wait", FLUSH, 1'b0, 1'b0);
        end
        nextCycle();
        #1;
        expectD("wait+", ADV, 1'b1, 1'b0);
        checkVal("wait.D.sc", 32'(scD), 32'd4);
        checkVal("wait.C.sc", 32'(scC), 32'd4);

        // Saturation: preload 16'hFFFE, then three stall cycles.
        nextCycle();
        force dutD.stallCount = 16'hFFFE;
        #1;
        release dutD.stallCount;
        imemReady = 1'b0;
        #1;
        checkVal("sat.pre", 32'(scD), 32'h0000FFFE);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            imemReady = 1'b0;
            #1;
            checkVal("sat", 32'(scD), 32'h0000FFFF);
        end
        nextCycle();
        #1;
        checkVal("sat.end", 32'(scD), 32'h0000FFFF);

        // Reset in the middle of dutC's load-use stall aborts it.
        nextCycle();
        exMemRead = 1'b1; exRd = 5'd12; idRs = 5'd12; idUsesRs = 1'b1;
        #1;
        expectC("luRst", HOLD, 1'b0, 1'b1);
        nextCycle();
        reset = 1'b1;
        #1;
        expectC("luRst+1", FLUSH, 1'b0, 1'b1);
        nextCycle();
        #1;
        expectC("luRst+2", ADV, 1'b1, 1'b0);
        checkVal("luRst.C.sc", 32'(scC), 32'd0);
        checkVal("luRst.D.sc", 32'(scD), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
